tdc_stream_rx: RTL
==================

// Module: tdc_stream_rx
// PURPOSE
//  Core-side receiver for the TDC output stream. Drives TDC_Oready and accepts the TDC_Odata/TDC_Oint/TDC_Onum/TDC_Olast beats of one measurement frame (0..3 echoes).
//  Reduces each frame to one record: echo count, strongest echo, and an abort flag. Records are buffered in a show-ahead FIFO toward the frame/pixel logic.
//  Sits in the 250 MHz clk domain. Stream inputs and TDC_INT arrive already synchronised to clk.
// PARAMETERS
//  FIFO_DEPTH  4   result FIFO entries, power of 2, >=2
//  TIMEOUT     64  max clk cycles between beats inside a frame before abort, >=2
//  DW          10  tof width
//  IW          5   intensity width
// PORTS
//  clk         in   1      250 MHz logic clock
//  rst_n       in   1      async reset, active low
//  TDC_Odata   in   DW     echo tof
//  TDC_Oint    in   IW     echo intensity
//  TDC_Onum    in   2      echoes in frame (0..3), stable for the whole frame
//  TDC_Olast   in   1      final beat marker (optional, may never assert)
//  TDC_Ovalid  in   1      beat valid
//  TDC_Oready  out  1      beat ready
//  TDC_INT     in   1      one-cycle pulse: measurement window ended
//  res_valid   out  1      FIFO head valid
//  res_ready   in   1      consumer pop
//  res_tof     out  DW     tof of strongest echo (0 if none)
//  res_int     out  IW     intensity of strongest echo (0 if none)
//  res_num     out  2      echoes actually received
//  res_abort   out  1      frame ended by timeout or TDC_INT, not by completion
//  frame_cnt   out  16     frames pushed, wraps at 0xFFFF->0
//  err_ovf     out  1      sticky: TDC_INT seen while FIFO full in IDLE; cleared only by reset
// BEHAVIOUR
//  Reset: TDC_Oready=0, res_valid=0, res_* =0, frame_cnt=0, err_ovf=0, FIFO empty, state IDLE.
//  Handshake: a beat transfers on a posedge where TDC_Ovalid & TDC_Oready. Every beat is consumed; none is ever dropped silently.
//  TDC_Oready=1 in IDLE when FIFO not full. TDC_Oready=1 in RECV. TDC_Oready=0 in PUSH.
//  FSM states:
//   IDLE: on the first beat, latch n=TDC_Onum, beats=1, best=beat, timer=0.
//    n==0 -> PUSH with num=0, tof/int=0 (empty-frame beat).
//    n==1 or TDC_Olast -> PUSH.
//    Otherwise -> RECV.
//   RECV, on a beat: beats++. If Oint > best_int (strictly), best := beat, so ties keep the earlier echo.
//    beats==n or TDC_Olast -> PUSH.
//   RECV, no beat: timer++. timer==TIMEOUT-1 -> PUSH with abort=1.
//   RECV, TDC_INT pulse without a beat -> PUSH with abort=1.
//   RECV, TDC_INT pulse with a beat in the same cycle -> beat counted first, then PUSH with abort=1 unless that beat completed the frame.
//   PUSH: write {best_tof,best_int,beats,abort} into FIFO, frame_cnt++, -> IDLE. Lasts 1 cycle.
//    PUSH is only reachable with FIFO not full, because IDLE gates ready on full.
//  Latency: final handshake at edge N; PUSH during cycle N..N+1; record written at edge N+1.
//   With FIFO empty, res_valid=1 and res_* are valid from edge N+1.
//  FIFO: show-ahead; pop when res_valid & res_ready. Push and pop in the same cycle are allowed when full or empty.
//  TDC_INT in IDLE: ignored, except err_ovf:=1 if FIFO full.
//  beats saturates at 3. TDC_Onum changing mid-frame is ignored; the latched n is used.
//  Async reset mid-frame discards the partial frame and the FIFO contents.
// TESTING
//  Frame Onum=3, beats (100,5),(200,9),(300,9) with Olast on the 3rd
//   -> one record tof=200 int=9 num=3 abort=0, res_valid at edge N+1.
//  Onum=0 single beat -> record num=0 tof=0 int=0 abort=0, frame_cnt=1.
//  Onum=2, one beat (50,3), then Ovalid low 64 cycles
//   -> record tof=50 int=3 num=1 abort=1 at timeout.
//  res_ready=0 with 4 complete frames sent -> TDC_Oready=0 in IDLE.
//   Then TDC_INT -> err_ovf=1. Pop once -> Oready=1 next cycle.
//  Onum=3, TDC_INT after 2nd beat -> record num=2 abort=1. Next frame is received normally.
//  Random Ovalid/res_ready gaps over 1000 frames vs model
//   -> records match in order, frame_cnt=1000, no lost beat.

Source files
------------

// File: rtl/tdc_stream_rx_if.sv
// TDC output stream: one beat per echo, valid/ready handshake.
// The TDC is the master and drives the beat; the receiver is the slave and drives ready.
interface tdc_stream_rx_if #(
   parameter int unsigned DW = 10,
   parameter int unsigned IW = 5
);
   logic [DW-1:0] TDC_Odata;
   logic [IW-1:0] TDC_Oint;
   logic [1:0]    TDC_Onum;
   logic          TDC_Olast;
   logic          TDC_Ovalid;
   logic          TDC_Oready;

   modport master (
      output TDC_Odata,
      output TDC_Oint,
      output TDC_Onum,
      output TDC_Olast,
      output TDC_Ovalid,
      input  TDC_Oready
   );

   modport slave (
      input  TDC_Odata,
      input  TDC_Oint,
      input  TDC_Onum,
      input  TDC_Olast,
      input  TDC_Ovalid,
      output TDC_Oready
   );
endinterface

// File: rtl/tdc_stream_rx.sv
// Core-side receiver for the TDC output stream. Each measurement frame (0..3 echo beats)
// is reduced to one record {strongest tof, strongest intensity, echoes received, abort}
// and queued in a small show-ahead FIFO toward the frame/pixel logic.
module tdc_stream_rx #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned TIMEOUT    = 64,
   parameter int unsigned DW         = 10,
   parameter int unsigned IW         = 5
) (
   input  logic                clk,
   input  logic                rst_n,
   tdc_stream_rx_if.slave      tdc,
   input  logic                TDC_INT,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [DW-1:0]       res_tof,
   output logic [IW-1:0]       res_int,
   output logic [1:0]          res_num,
   output logic                res_abort,
   output logic [15:0]         frame_cnt,
   output logic                err_ovf
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned TW = $clog2(TIMEOUT);
   localparam int unsigned RW = DW + IW + 3;

   typedef enum logic [1:0] {
      StIdle,
      StRecv,
      StPush
   } state_e;

   state_e          state_q;
   logic            ready_q;
   logic [1:0]      n_q;
   logic [1:0]      beats_q;
   logic [DW-1:0]   best_tof_q;
   logic [IW-1:0]   best_int_q;
   logic [TW-1:0]   timer_q;
   logic            abort_q;
   logic [15:0]     frame_cnt_q;
   logic            err_ovf_q;

   logic [RW-1:0]   mem_q [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_q;
   logic [AW-1:0]   rd_ptr_q;
   logic [CW-1:0]   cnt_q;
   logic [CW-1:0]   cnt_d;

   logic            beat;
   logic            push;
   logic            pop;
   logic            full;
   logic            full_d;
   logic [1:0]      beats_inc;
   logic            frame_done;
   logic            stronger;
   logic [RW-1:0]   head;

   assign tdc.TDC_Oready = ready_q;
   assign frame_cnt      = frame_cnt_q;
   assign err_ovf        = err_ovf_q;

   // Handshake, FIFO occupancy and per-beat decisions shared by the FSM.
   always_comb begin
      beat       = tdc.TDC_Ovalid & ready_q;
      full       = (cnt_q == CW'(FIFO_DEPTH));
      res_valid  = (cnt_q != '0);
      pop        = res_valid & res_ready;
      // PUSH is never entered with the FIFO full, the guard only keeps the pointers safe.
      push       = (state_q == StPush) & (~full | pop);
      beats_inc  = (beats_q == 2'd3) ? 2'd3 : beats_q + 2'd1;
      frame_done = (beats_inc == n_q) | tdc.TDC_Olast;
      // Strictly greater: on equal intensity the earlier echo stays the winner.
      stronger   = (tdc.TDC_Oint > best_int_q);
      cnt_d      = cnt_q;
      unique case ({push, pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
      full_d     = (cnt_d == CW'(FIFO_DEPTH));
   end

   // Frame reduction FSM; TDC_Oready is registered and computed from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         ready_q     <= 1'b0;
         n_q         <= 2'd0;
         beats_q     <= 2'd0;
         best_tof_q  <= '0;
         best_int_q  <= '0;
         timer_q     <= '0;
         abort_q     <= 1'b0;
         frame_cnt_q <= 16'd0;
         err_ovf_q   <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               // A window ending while no room is left means a frame could be lost upstream.
               if (TDC_INT && full) begin
                  err_ovf_q <= 1'b1;
               end
               if (beat) begin
                  n_q     <= tdc.TDC_Onum;
                  timer_q <= '0;
                  abort_q <= 1'b0;
                  if (tdc.TDC_Onum == 2'd0) begin
                     // Empty-frame marker beat: carries no echo.
                     beats_q    <= 2'd0;
                     best_tof_q <= '0;
                     best_int_q <= '0;
                     state_q    <= StPush;
                     ready_q    <= 1'b0;
                  end else begin
                     beats_q    <= 2'd1;
                     best_tof_q <= tdc.TDC_Odata;
                     best_int_q <= tdc.TDC_Oint;
                     if ((tdc.TDC_Onum == 2'd1) || tdc.TDC_Olast) begin
                        state_q <= StPush;
                        ready_q <= 1'b0;
                     end else begin
                        state_q <= StRecv;
                        ready_q <= 1'b1;
                     end
                  end
               end else begin
                  ready_q <= ~full_d;
               end
            end

            StRecv: begin
               if (beat) begin
                  beats_q <= beats_inc;
                  timer_q <= '0;
                  if (stronger) begin
                     best_tof_q <= tdc.TDC_Odata;
                     best_int_q <= tdc.TDC_Oint;
                  end
                  if (frame_done) begin
                     // A completing beat wins over a coincident window end.
                     abort_q <= 1'b0;
                     state_q <= StPush;
                     ready_q <= 1'b0;
                  end else if (TDC_INT) begin
                     abort_q <= 1'b1;
                     state_q <= StPush;
                     ready_q <= 1'b0;
                  end else begin
                     ready_q <= 1'b1;
                  end
               end else if (TDC_INT || (timer_q == TW'(TIMEOUT - 1))) begin
                  abort_q <= 1'b1;
                  state_q <= StPush;
                  ready_q <= 1'b0;
               end else begin
                  timer_q <= timer_q + TW'(1);
                  ready_q <= 1'b1;
               end
            end

            StPush: begin
               frame_cnt_q <= frame_cnt_q + 16'd1;
               state_q     <= StIdle;
               ready_q     <= ~full_d;
            end

            default: begin
               state_q <= StIdle;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   // Result FIFO storage and pointers; depth is a power of two so pointers wrap naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         cnt_q <= cnt_d;
         if (push) begin
            mem_q[wr_ptr_q] <= {best_tof_q, best_int_q, beats_q, abort_q};
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
      end
   end

   // Show-ahead head; fields read as zero while the FIFO is empty.
   always_comb begin
      head      = res_valid ? mem_q[rd_ptr_q] : '0;
      res_tof   = head[RW-1 -: DW];
      res_int   = head[IW+2 : 3];
      res_num   = head[2:1];
      res_abort = head[0];
   end

endmodule
